// File: rtl/result_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : result_pkg
//  Purpose  : Default widths for the result packer and the shared
//             round-half-up / saturate helper used on every accepted result.
//  Revision : 1.0  initial release
// ============================================================================
package result_pkg;

    localparam int ACC_W_DEF   = 24;
    localparam int OUT_W_DEF   = 16;
    localparam int DEPTH_DEF   = 8;
    localparam int VEC_LEN_DEF = 8;

    // Wide enough to hold any ACC_W plus the rounding bias without overflow.
    localparam int C_CALC_W = 64;

    typedef struct packed {
        logic                        sat;
        logic signed [C_CALC_W-1:0]  data;
    } quant_t;

    // Arithmetic right shift with half-up rounding, then clamp to a signed
    // out_w-bit range. acc must already be sign-extended to C_CALC_W bits.
    function automatic quant_t quant_sat(
        input logic signed [C_CALC_W-1:0] acc,
        input logic        [4:0]          shift,
        input int                         out_w
    );
        quant_t                     r;
        logic signed [C_CALC_W-1:0] v;
        logic signed [C_CALC_W-1:0] hi;
        logic signed [C_CALC_W-1:0] lo;
        v = acc;
        if (shift != 5'd0) begin
            v = (acc + (64'sd1 <<< (shift - 5'd1))) >>> shift;
        end
        hi     = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo     = -(64'sd1 <<< (out_w - 1));
        r.sat  = 1'b0;
        r.data = v;
        if (v > hi) begin
            r.data = hi;
            r.sat  = 1'b1;
        end else if (v < lo) begin
            r.data = lo;
            r.sat  = 1'b1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : result_packer_if
//  Purpose  : Upstream result handshake plus downstream packed-word stream.
//             master = environment side, slave = packer side.
//  Revision : 1.0  initial release
// ============================================================================
interface result_packer_if #(
    parameter int ACC_W = 24,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] in_data;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;
    logic             m_last;

    modport master (
        output in_valid, in_data, m_ready,
        input  in_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  in_valid, in_data, m_ready,
        output in_ready, m_valid, m_data, m_last
    );
endinterface
`default_nettype wire

// File: rtl/result_packer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : result_fifo
//  Purpose  : Single-clock synchronous FIFO with occupancy count. Head word
//             is presented combinationally from storage, zero when empty.
//  Revision : 1.0  initial release
// ============================================================================
module result_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_wdata,
    input  wire logic                       i_pop,
    output logic      [WIDTH-1:0]           o_rdata,
    output logic      [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [WIDTH-1:0] w_mem_d [DEPTH];
    logic [PTR_W-1:0] r_wptr_q, w_wptr_d;
    logic [PTR_W-1:0] r_rptr_q, w_rptr_d;
    logic [CNT_W-1:0] r_count_q, w_count_d;
    logic             w_do_push;
    logic             w_do_pop;

    // Next-state for storage, pointers and count; pointers wrap naturally.
    always_comb begin
        w_do_push = i_push && (r_count_q != CNT_W'(DEPTH));
        w_do_pop  = i_pop && (r_count_q != '0);
        w_mem_d   = r_mem_q;
        w_wptr_d  = r_wptr_q;
        w_rptr_d  = r_rptr_q;
        w_count_d = r_count_q;
        if (w_do_push) begin
            w_mem_d[r_wptr_q] = i_wdata;
            w_wptr_d          = r_wptr_q + PTR_W'(1);
        end
        if (w_do_pop) begin
            w_rptr_d = r_rptr_q + PTR_W'(1);
        end
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_d = r_count_q + CNT_W'(1);
            2'b01:   w_count_d = r_count_q - CNT_W'(1);
            default: w_count_d = r_count_q;
        endcase
    end

    // Storage needs no reset: it is never observed while the count is zero.
    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_wptr_q  <= w_wptr_d;
            r_rptr_q  <= w_rptr_d;
            r_count_q <= w_count_d;
        end
    end

    assign o_rdata = (r_count_q != '0) ? r_mem_q[r_rptr_q] : '0;
    assign o_count = r_count_q;

endmodule
`default_nettype wire

// File: rtl/result_packer.sv
`default_nettype none
// ============================================================================
//  Module   : result_packer
//  Purpose  : Quantizes accumulator results (round half up, saturate), tags
//             vector boundaries and buffers packed words toward downstream.
//  Revision : 1.0  initial release
// ============================================================================
module result_packer
    import result_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int VEC_LEN = VEC_LEN_DEF
) (
    input  wire logic       clk,
    input  wire logic       rst,
    result_packer_if.slave  bus,
    input  wire logic [4:0] quant_shift,
    input  wire logic       clear_sat,
    output logic            sat_flag
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int VEC_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    logic [CNT_W-1:0]           w_count;
    logic                       w_accept;
    logic                       w_xfer;
    logic signed [C_CALC_W-1:0] w_acc_ext;
    quant_t                     w_q;
    logic                       w_hi_ovf;
    logic                       w_sat_hit;
    logic                       w_last;
    logic [OUT_W:0]             w_fifo_wdata;
    logic [OUT_W:0]             w_fifo_rdata;
    logic [VEC_W-1:0]           r_vec_q, w_vec_d;
    logic                       r_sat_q, w_sat_d;

    // Handshake status comes only from the registered FIFO count.
    assign bus.in_ready = (w_count < CNT_W'(DEPTH));
    assign bus.m_valid  = (w_count != '0);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_xfer       = bus.m_valid && bus.m_ready;

    // Quantize the incoming result at the full calculation width.
    assign w_acc_ext = {{(C_CALC_W-ACC_W){bus.in_data[ACC_W-1]}}, bus.in_data};
    assign w_q       = quant_sat(w_acc_ext, quant_shift, OUT_W);

    // After clamping, bits above OUT_W-1 are pure sign extension; any other
    // pattern would wrap on truncation, so it is treated as saturation too.
    assign w_hi_ovf  = !((&w_q.data[C_CALC_W-1:OUT_W-1]) || !(|w_q.data[C_CALC_W-1:OUT_W-1]));
    assign w_sat_hit = w_q.sat || w_hi_ovf;

    assign w_last       = (r_vec_q == VEC_W'(VEC_LEN - 1));
    assign w_fifo_wdata = {w_last, w_q.data[OUT_W-1:0]};

    // Vector position and sticky saturation; a same-cycle clamp beats clear.
    always_comb begin
        w_vec_d = r_vec_q;
        w_sat_d = r_sat_q;
        if (w_accept) begin
            w_vec_d = w_last ? '0 : r_vec_q + VEC_W'(1);
        end
        if (clear_sat) begin
            w_sat_d = 1'b0;
        end
        if (w_accept && w_sat_hit) begin
            w_sat_d = 1'b1;
        end
    end

    // Vector counter and saturation flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec_q <= '0;
            r_sat_q <= 1'b0;
        end else begin
            r_vec_q <= w_vec_d;
            r_sat_q <= w_sat_d;
        end
    end

    result_fifo #(
        .WIDTH (OUT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_xfer),
        .o_rdata (w_fifo_rdata),
        .o_count (w_count)
    );

    assign {bus.m_last, bus.m_data} = w_fifo_rdata;
    assign sat_flag = r_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_result_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_packer
//  Purpose  : Directed and randomized-handshake bench for result_packer with
//             a queue scoreboard checked by an independent monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_result_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] quant_shift = 5'd0;
    logic       clear_sat = 1'b0;
    logic       sat_flag;

    result_packer_if #(.ACC_W(24), .OUT_W(16)) bus ();

    result_packer #(
        .ACC_W   (24),
        .OUT_W   (16),
        .DEPTH   (8),
        .VEC_LEN (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .quant_shift (quant_shift),
        .clear_sat   (clear_sat),
        .sat_flag    (sat_flag)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_q[$];
    logic [16:0] mon_e;
    int          tb_vec = 0;
    bit          tb_sat = 1'b0;
    bit          rnd_en = 1'b0;

    typedef struct {
        int          sh;
        logic [23:0] d;
        logic [15:0] e;
        bit          clr;
        bit          s;
    } vec_t;

    vec_t tbl[15] = '{
        '{4,  24'h000018, 16'h0002, 1'b0, 1'b0},
        '{4,  24'hFFFFE8, 16'hFFFF, 1'b0, 1'b0},
        '{4,  24'h7FFFFF, 16'h7FFF, 1'b0, 1'b1},
        '{4,  24'h800000, 16'h8000, 1'b0, 1'b1},
        '{4,  24'h000123, 16'h0012, 1'b1, 1'b0},
        '{4,  24'h7FFFFF, 16'h7FFF, 1'b1, 1'b1},
        '{4,  24'h000010, 16'h0001, 1'b1, 1'b0},
        '{0,  24'h000005, 16'h0005, 1'b0, 1'b0},
        '{0,  24'h00FFFF, 16'h7FFF, 1'b0, 1'b1},
        '{0,  24'hFF0000, 16'h8000, 1'b1, 1'b1},
        '{1,  24'hFFFFFD, 16'hFFFF, 1'b1, 1'b0},
        '{1,  24'hFFFFFF, 16'h0000, 1'b0, 1'b0},
        '{8,  24'h012380, 16'h0124, 1'b0, 1'b0},
        '{24, 24'h7FFFFF, 16'h0000, 1'b0, 1'b0},
        '{31, 24'h800000, 16'h0000, 1'b0, 1'b0}
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference quantizer: floor division form of round-half-up, then clamp.
    function automatic logic [15:0] model_q(input logic [23:0] x, input int s, output bit sat);
        longint v;
        longint num;
        longint den;
        longint q;
        v   = longint'($signed(x));
        q   = v;
        if (s > 0) begin
            den = longint'(1) << s;
            num = v + den / 2;
            q   = num / den;
            if ((num % den != 0) && (num < 0)) q = q - 1;
        end
        sat = 1'b0;
        if (q > 32767) begin
            q = 32767; sat = 1'b1;
        end else if (q < -32768) begin
            q = -32768; sat = 1'b1;
        end
        return q[15:0];
    endfunction

    // Monitor: every transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h expected none", {bus.m_last, bus.m_data});
            end else begin
                mon_e = exp_q.pop_front();
                check("word", {15'd0, bus.m_last, bus.m_data}, {15'd0, mon_e});
            end
        end
    end

    // Offer one result and hold in_valid until accepted; records expectation.
    task automatic send(input logic [23:0] d, input logic [15:0] ed, input bit es);
        int n;
        n            = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got in_ready=0 expected 1");
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (rnd_en) bus.m_ready = 1'($urandom_range(0, 1));
        end
        exp_q.push_back({(tb_vec == 7), ed});
        tb_vec = (tb_vec + 1) % 8;
        if (es) tb_sat = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n           = 0;
        bus.m_ready = 1'b1;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit offer);
        rst          = 1'b1;
        bus.in_valid = offer;
        bus.in_data  = 24'h000055;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        tb_vec = 0;
        tb_sat = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_m_valid"},  {31'd0, bus.m_valid},  32'd0);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({tag, "_m_data"},   {16'd0, bus.m_data},   32'd0);
        check({tag, "_m_last"},   {31'd0, bus.m_last},   32'd0);
        check({tag, "_sat"},      {31'd0, sat_flag},     32'd0);
    endtask

    initial begin
        logic [15:0] md;
        logic [23:0] rd;
        bit          ms;
        int          shifts[3] = '{0, 7, 12};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.m_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset");

        // Latency: word visible the cycle after its accept, held while stalled.
        quant_shift = 5'd4;
        send(24'h000123, 16'h0012, 1'b0);
        bus.in_valid = 1'b0;
        check("latency_m_valid", {31'd0, bus.m_valid}, 32'd1);
        check("latency_m_data", {16'd0, bus.m_data}, 32'h0012);
        drain();

        // Directed quantize / saturate / sticky-flag vectors.
        foreach (tbl[i]) begin
            if (5'(tbl[i].sh) != quant_shift) begin
                drain();
                quant_shift = 5'(tbl[i].sh);
            end
            clear_sat = tbl[i].clr;
            send(tbl[i].d, tbl[i].e, tbl[i].s);
            bus.in_valid = 1'b0;
            clear_sat    = 1'b0;
            check($sformatf("sat_flag_%0d", i), {31'd0, sat_flag}, {31'd0, tbl[i].s});
        end
        drain();

        // Fill to DEPTH with downstream stalled; ninth result must wait.
        quant_shift = 5'd0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(24'(i + 1), 16'(i + 1), 1'b0);
        check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_data = 24'd9;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("stall_m_data", {16'd0, bus.m_data}, 32'd1);
        end
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_xfer", {31'd0, bus.in_ready}, 32'd1);
        send(24'd9, 16'd9, 1'b0);
        bus.in_valid = 1'b0;
        drain();

        // Back-to-back 16 results from a fresh vector: last on 8th and 16th.
        do_reset(1'b0);
        check_idle("reset2");
        bus.m_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(24'(i * 3), 16'(i * 3), 1'b0);
        bus.in_valid = 1'b0;
        drain();

        // Reset mid-vector with an accept offered during reset.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(24'(100 + i), 16'(100 + i), 1'b0);
        bus.in_valid = 1'b0;
        do_reset(1'b1);
        check_idle("reset3");
        for (int i = 0; i < 8; i++) send(24'(200 + i), 16'(200 + i), 1'b0);
        bus.in_valid = 1'b0;
        drain();

        // Randomized handshakes and data against the reference model.
        foreach (shifts[k]) begin
            quant_shift = 5'(shifts[k]);
            rnd_en      = 1'b1;
            for (int i = 0; i < 600; i++) begin
                bus.m_ready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) < 3) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                rd = 24'($urandom);
                md = model_q(rd, shifts[k], ms);
                send(rd, md, ms);
            end
            bus.in_valid = 1'b0;
            rnd_en       = 1'b0;
            drain();
            check($sformatf("rand_sat_%0d", k), {31'd0, sat_flag}, {31'd0, tb_sat});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
